mem_interface: RTL and testbench

- Word-organised instruction/data memory that sits directly upstream of the control unit.
- Answers the control unit's fetch/valid/RW request with a ready-low-then-ready-high handshake and a 32-bit data word.
- Also accepts writes, so later load/store stages can share the same port.
- The array is internal; read and write latency is a fixed, parameterised number of cycles.

---
 rtl/mem_interface_pkg.sv | 16 +
 rtl/mem_interface_mem_array.sv | 22 ++
 rtl/mem_interface.sv | 122 ++++++++++++
 tb/tb_mem_interface.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/mem_interface_pkg.sv
// Shared encodings and constants for the mem_interface handshake memory.
// ALIGN_CHECK_EN (optional macro) enables the misaligned-access error path.
package mem_interface_pkg;
   localparam int WORD_W = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic RW_READ  = 1'b1;
   localparam logic RW_WRITE = 1'b0;

   localparam logic [WORD_W-1:0] MISALIGN_PATTERN = 32'hDEAD_BEEF;
endpackage

// File: rtl/mem_interface_mem_array.sv
// Single-port synchronous RAM, DEPTH x 32, write enable and registered read.
// Part of mem_interface; ALIGN_CHECK_EN has no effect here.
module mem_array
   import mem_interface_pkg::*;
#(
   parameter int DEPTH  = 1024,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [WORD_W-1:0] i_wdata,
   output logic [WORD_W-1:0] o_rdata
);
   logic [WORD_W-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we)
         r_mem[i_addr] <= i_wdata;
      o_rdata <= r_mem[i_addr];
   end
endmodule

// File: rtl/mem_interface.sv
// Word memory behind a fetch/valid/RW handshake with fixed access latency.
// Define ALIGN_CHECK_EN to flag addr[1:0]!=0 accesses via err and DEAD_BEEF data.
module mem_interface
   import mem_interface_pkg::*;
#(
   parameter int DEPTH   = 1024,
   parameter int ADDR_W  = 10,
   parameter int LATENCY = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              fetch,
   input  logic              valid,
   input  logic              RW,
   input  logic [31:0]       addr,
   input  logic [WORD_W-1:0] wdata,
   output logic [WORD_W-1:0] data,
   output logic              ready,
   output logic              err
);
   localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   state_t            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [ADDR_W-1:0] r_idx;
   logic              r_rw;
   logic [WORD_W-1:0] r_wdata;
   logic              r_mis;
   logic              r_ready;
   logic [WORD_W-1:0] r_data;

   logic              w_req;
   logic [ADDR_W-1:0] w_idx_in;
   logic [ADDR_W-1:0] w_ram_addr;
   logic              w_last;
   logic              w_we;
   logic              w_mis_in;
   logic [WORD_W-1:0] w_rdata;
   logic              w_unused_addr;

   assign w_req         = fetch & valid;
   assign w_idx_in      = addr[ADDR_W+1:2];
   assign w_unused_addr = ^{addr[31:ADDR_W+2], addr[1:0]};

   // Present the incoming index while idle so the RAM's registered read is
   // already valid on the first BUSY cycle, even with LATENCY=1.
   assign w_ram_addr = (r_state == IDLE) ? w_idx_in : r_idx;
   assign w_last     = (r_state == BUSY) && (r_cnt == '0);
   assign w_we       = w_last && (r_rw == RW_WRITE) && !r_mis && !reset;

`ifdef ALIGN_CHECK_EN
   logic r_err;
   assign w_mis_in = |addr[1:0];
   assign err      = r_err;
`else
   assign w_mis_in = 1'b0;
   assign err      = 1'b0;
`endif

   assign data  = r_data;
   assign ready = r_ready;

   mem_array #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
      .clk     (clk),
      .i_we    (w_we),
      .i_addr  (w_ram_addr),
      .i_wdata (r_wdata),
      .o_rdata (w_rdata)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_ready <= 1'b1;
         r_data  <= '0;
         r_cnt   <= '0;
`ifdef ALIGN_CHECK_EN
         r_err   <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (w_req) begin
                  r_idx   <= w_idx_in;
                  r_rw    <= RW;
                  r_wdata <= wdata;
                  r_mis   <= w_mis_in;
                  r_cnt   <= CNT_W'(LATENCY - 1);
                  r_ready <= 1'b0;
                  r_state <= BUSY;
               end
            end
            BUSY: begin
               if (r_cnt == '0) begin
                  r_state <= DONE;
                  r_ready <= 1'b1;
                  if (r_mis) begin
                     r_data <= MISALIGN_PATTERN;
`ifdef ALIGN_CHECK_EN
                     r_err  <= 1'b1;
`endif
                  end else if (r_rw == RW_READ)
                     r_data <= w_rdata;
                  else
                     r_data <= r_wdata;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            DONE: begin
               if (!fetch) begin
                  r_state <= IDLE;
`ifdef ALIGN_CHECK_EN
                  r_err   <= 1'b0;
`endif
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_interface.sv
// Self-checking bench for mem_interface: directed handshake scenarios plus
// randomized traffic against a word-array reference model.
module tb_mem_interface;
   localparam int DEPTH   = 1024;
   localparam int ADDR_W  = 10;
   localparam int LATENCY = 2;

   logic        clk = 1'b0;
   logic        reset, fetch, valid, RW;
   logic [31:0] addr, wdata, data;
   logic        ready, err;

   int checks   = 0;
   int failures = 0;

   logic [31:0] model   [DEPTH];
   bit          written [DEPTH];
   logic [31:0] last_data;

   mem_interface #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
      .clk(clk), .reset(reset), .fetch(fetch), .valid(valid), .RW(RW),
      .addr(addr), .wdata(wdata), .data(data), .ready(ready), .err(err)
   );

   always #5 clk = ~clk;

   function automatic int widx(input logic [31:0] a);
      return int'((a / 4) % DEPTH);
   endfunction

   // Drives one full handshake from IDLE and back; returns observations only.
   task automatic access(input logic rw, input logic [31:0] a, input logic [31:0] wd,
                         output int lows, output logic [31:0] rd_done, output logic e_done,
                         output logic [31:0] rd_hold, output logic rdy_hold,
                         output logic [31:0] rd_after, output logic e_after,
                         output logic rdy_after, output bit to);
      int i;
      fetch = 1'b1; valid = 1'b1; RW = rw; addr = a; wdata = wd;
      lows = 0; to = 1'b0;
      for (i = 0; i < 20; i++) begin
         @(posedge clk); @(negedge clk);
         // scramble inputs after acceptance; they must be ignored
         addr = $urandom; wdata = $urandom; RW = 1'($urandom); valid = 1'($urandom);
         if (ready) break;
         lows++;
      end
      if (i == 20) to = 1'b1;
      rd_done = data; e_done = err;
      @(posedge clk); @(negedge clk);
      rd_hold = data; rdy_hold = ready;
      fetch = 1'b0; valid = 1'b0;
      @(posedge clk); @(negedge clk);
      rd_after = data; e_after = err; rdy_after = ready;
   endtask

   task automatic test_reset;
      reset = 1'b1; fetch = 1'b0; valid = 1'b0; RW = 1'b1; addr = '0; wdata = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); @(negedge clk);
      checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready); end
      checks++; if (data !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", data); end
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
      last_data = 32'h0;
   endtask

   task automatic test_write_read;
      int lows; logic [31:0] rd, rh, ra; logic e, ea, rdyh, rdya; bit to;
      access(1'b0, 32'h10, 32'h1234_5678, lows, rd, e, rh, rdyh, ra, ea, rdya, to);
      model[4] = 32'h1234_5678; written[4] = 1'b1;
      checks++; if (to || lows != LATENCY) begin failures++; $display("FAIL wr_latency got=%0d exp=%0d to=%0b", lows, LATENCY, to); end
      checks++; if (rd !== 32'h1234_5678) begin failures++; $display("FAIL wr_data got=%h exp=12345678", rd); end
      checks++; if (rdya !== 1'b1 || ra !== 32'h1234_5678) begin failures++; $display("FAIL wr_idle got rdy=%b data=%h", rdya, ra); end
      access(1'b1, 32'h10, 32'h0, lows, rd, e, rh, rdyh, ra, ea, rdya, to);
      checks++; if (to || lows != LATENCY) begin failures++; $display("FAIL rd_latency got=%0d exp=%0d", lows, LATENCY); end
      checks++; if (rd !== 32'h1234_5678) begin failures++; $display("FAIL rd_data got=%h exp=12345678", rd); end
      checks++; if (rh !== 32'h1234_5678 || rdyh !== 1'b1) begin failures++; $display("FAIL rd_hold got data=%h rdy=%b", rh, rdyh); end
      checks++; if (ra !== 32'h1234_5678) begin failures++; $display("FAIL rd_after_drop got=%h exp=12345678", ra); end
      last_data = ra;
   endtask

   task automatic test_wrap;
      int lows; logic [31:0] rd, rh, ra; logic e, ea, rdyh, rdya; bit to;
      access(1'b1, 32'h10 + DEPTH*4, 32'h0, lows, rd, e, rh, rdyh, ra, ea, rdya, to);
      checks++; if (to || rd !== 32'h1234_5678) begin failures++; $display("FAIL wrap_read got=%h exp=12345678", rd); end
      last_data = ra;
   endtask

   task automatic test_fetch_no_valid;
      fetch = 1'b1; valid = 1'b0; RW = 1'b0; addr = 32'h40; wdata = 32'hFFFF_FFFF;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); @(negedge clk);
         checks++;
         if (ready !== 1'b1 || data !== last_data) begin
            failures++; $display("FAIL novalid_idle cyc=%0d rdy=%b data=%h exp_data=%h", i, ready, data, last_data);
         end
      end
      fetch = 1'b0;
      @(posedge clk); @(negedge clk);
   endtask

   task automatic test_reset_midwrite;
      int lows; logic [31:0] rd, rh, ra; logic e, ea, rdyh, rdya; bit to;
      access(1'b0, 32'h20, 32'h0BAD_F00D, lows, rd, e, rh, rdyh, ra, ea, rdya, to);
      model[8] = 32'h0BAD_F00D; written[8] = 1'b1;
      fetch = 1'b1; valid = 1'b1; RW = 1'b0; addr = 32'h20; wdata = 32'hAAAA_AAAA;
      @(posedge clk); @(negedge clk);
      checks++; if (ready !== 1'b0) begin failures++; $display("FAIL midwr_busy got rdy=%b exp=0", ready); end
      reset = 1'b1;
      @(posedge clk); @(negedge clk);
      checks++; if (ready !== 1'b1 || data !== 32'h0) begin failures++; $display("FAIL midwr_reset got rdy=%b data=%h", ready, data); end
      reset = 1'b0; fetch = 1'b0; valid = 1'b0;
      @(posedge clk); @(negedge clk);
      access(1'b1, 32'h20, 32'h0, lows, rd, e, rh, rdyh, ra, ea, rdya, to);
      checks++; if (to || rd !== 32'h0BAD_F00D) begin failures++; $display("FAIL midwr_old got=%h exp=0badf00d", rd); end
      last_data = ra;
   endtask

   task automatic test_random;
      int lows, idx; logic [31:0] a, wd, exp, rd, rh, ra; logic rw, e, ea, rdyh, rdya; bit to;
      for (int n = 0; n < 40; n++) begin
         idx = int'($urandom_range(0, 15)) * 37 % DEPTH;
         a   = {$urandom_range(0, 255), 12'h0} | (32'(idx) << 2);
         wd  = $urandom;
         rw  = written[idx] ? 1'($urandom) : 1'b0;
         exp = rw ? model[idx] : wd;
         access(rw, a, wd, lows, rd, e, rh, rdyh, ra, ea, rdya, to);
         if (!rw) begin model[widx(a)] = wd; written[widx(a)] = 1'b1; end
         checks++;
         if (to || lows != LATENCY || rd !== exp || rh !== exp || ra !== exp || e !== 1'b0 || rdya !== 1'b1) begin
            failures++;
            $display("FAIL rand_%0d rw=%b addr=%h lows=%0d got=%h/%h/%h exp=%h err=%b", n, rw, a, lows, rd, rh, ra, exp, e);
         end
         last_data = ra;
      end
   endtask

   task automatic test_align;
      int lows; logic [31:0] rd, rh, ra; logic e, ea, rdyh, rdya; bit to;
`ifdef ALIGN_CHECK_EN
      access(1'b1, 32'h11, 32'h0, lows, rd, e, rh, rdyh, ra, ea, rdya, to);
      checks++; if (to || lows != LATENCY || rd !== 32'hDEAD_BEEF || e !== 1'b1) begin failures++; $display("FAIL mis_read got=%h err=%b lows=%0d", rd, e, lows); end
      checks++; if (ea !== 1'b0) begin failures++; $display("FAIL mis_err_clear got=%b exp=0", ea); end
      access(1'b0, 32'h13, 32'hFFFF_0000, lows, rd, e, rh, rdyh, ra, ea, rdya, to);
      checks++; if (rd !== 32'hDEAD_BEEF || e !== 1'b1) begin failures++; $display("FAIL mis_write got=%h err=%b", rd, e); end
`else
      access(1'b1, 32'h13, 32'h0, lows, rd, e, rh, rdyh, ra, ea, rdya, to);
      checks++; if (to || rd !== model[4] || e !== 1'b0) begin failures++; $display("FAIL lowbits_read got=%h exp=%h err=%b", rd, model[4], e); end
      access(1'b0, 32'h12, 32'h5A5A_5A5A, lows, rd, e, rh, rdyh, ra, ea, rdya, to);
      model[4] = 32'h5A5A_5A5A;
`endif
      access(1'b1, 32'h10, 32'h0, lows, rd, e, rh, rdyh, ra, ea, rdya, to);
      checks++; if (to || rd !== model[4]) begin failures++; $display("FAIL align_mem4 got=%h exp=%h", rd, model[4]); end
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) begin model[i] = '0; written[i] = 1'b0; end
      test_reset();
      test_write_read();
      test_wrap();
      test_fetch_no_valid();
      test_reset_midwrite();
      test_random();
      test_align();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
